// File: rtl/modulation_pkg.sv
// Shared definitions for the modulation pipe: compare-mode encoding and pipeline limits.
package modulation_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_EQ         = 2'd0;
  localparam mode_t MODE_NE         = 2'd1;
  localparam mode_t MODE_SLT        = 2'd2;
  localparam mode_t MODE_FORCE_ELSE = 2'd3;

  localparam int DEPTH_MAX = 16;

endpackage

// File: rtl/delay_pipe.sv
// Tokened shift register: tokens always advance, data only advances with a token,
// so the output word holds its last valid value across bubbles.
module delay_pipe #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_tok,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic [DEPTH-1:0] o_tok
);

  logic [DEPTH-1:0] r_tok;
  logic [WIDTH-1:0] r_data [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tok <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
      end
    end else begin
      r_tok[0] <= i_tok;
      if (i_tok) begin
        r_data[0] <= i_data;
      end
      for (int i = 1; i < DEPTH; i++) begin
        r_tok[i] <= r_tok[i-1];
        if (r_tok[i-1]) begin
          r_data[i] <= r_data[i-1];
        end
      end
    end
  end

  assign o_data = r_data[DEPTH-1];
  assign o_tok  = r_tok;

endmodule

// File: rtl/modulation_branch_delay.sv
// Per-lane compare/select of array_ref vs array_ref_m, registered with a token and then
// delayed through a DEPTH-stage tokened pipe; accepts one operand set per cycle.
module modulation_branch_delay
  import modulation_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 8,
  parameter int DEPTH    = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  mode_t                     mode,
  input  logic [CHANNELS*WIDTH-1:0] input_bit,
  input  logic [WIDTH-1:0]          zero,
  input  logic [CHANNELS*WIDTH-1:0] array_ref,
  input  logic [CHANNELS*WIDTH-1:0] array_ref_m,
  output logic [CHANNELS*WIDTH-1:0] segment,
  output logic                      valid,
  output logic                      busy
);

  localparam int BUS = CHANNELS * WIDTH;
  // The output stage's token is excluded from busy so busy drops with the final valid.
  localparam logic [DEPTH-1:0] LAST_TOK = DEPTH'(1) << (DEPTH - 1);

  logic [BUS-1:0]   w_selected;
  logic [BUS-1:0]   r_stage0Data;
  logic             r_stage0Tok;
  logic [DEPTH-1:0] w_pipeTok;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    logic [WIDTH-1:0] w_cond;
    logic             w_take;

    assign w_cond = input_bit[k*WIDTH +: WIDTH];

    always_comb begin
      w_take = 1'b0;
      case (mode)
        MODE_EQ:  w_take = (w_cond == zero);
        MODE_NE:  w_take = (w_cond != zero);
        MODE_SLT: w_take = ($signed(w_cond) < $signed(zero));
        default:  w_take = 1'b0;
      endcase
    end

    assign w_selected[k*WIDTH +: WIDTH] = w_take ? array_ref[k*WIDTH +: WIDTH]
                                                 : array_ref_m[k*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stage0Tok  <= 1'b0;
      r_stage0Data <= '0;
    end else begin
      r_stage0Tok <= start;
      if (start) begin
        r_stage0Data <= w_selected;
      end
    end
  end

  delay_pipe #(
    .WIDTH(BUS),
    .DEPTH(DEPTH)
  ) u_pipe (
    .clk   (clk),
    .reset (reset),
    .i_tok (r_stage0Tok),
    .i_data(r_stage0Data),
    .o_data(segment),
    .o_tok (w_pipeTok)
  );

  assign valid = w_pipeTok[DEPTH-1];
  assign busy  = r_stage0Tok | (|(w_pipeTok & ~LAST_TOK));

endmodule

// File: tb/tb_modulation_branch_delay.sv
// Directed bench for modulation_branch_delay: three instances (DEPTH 1, 3, 4) share one
// stimulus bus; each scenario checks the instance whose depth it targets.
module tb_modulation_branch_delay;
  import modulation_pkg::*;

  localparam int W   = 32;
  localparam int C   = 8;
  localparam int BUS = W * C;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  mode_t          mode;
  logic [BUS-1:0] inBit;
  logic [W-1:0]   zero;
  logic [BUS-1:0] arRef;
  logic [BUS-1:0] arRefM;

  logic [BUS-1:0] seg1, seg3, seg4;
  logic           val1, val3, val4;
  logic           busy1, busy3, busy4;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  modulation_branch_delay #(.WIDTH(W), .CHANNELS(C), .DEPTH(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .input_bit(inBit), .zero(zero),
    .array_ref(arRef), .array_ref_m(arRefM), .segment(seg1), .valid(val1), .busy(busy1));

  modulation_branch_delay #(.WIDTH(W), .CHANNELS(C), .DEPTH(3)) dut3 (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .input_bit(inBit), .zero(zero),
    .array_ref(arRef), .array_ref_m(arRefM), .segment(seg3), .valid(val3), .busy(busy3));

  modulation_branch_delay #(.WIDTH(W), .CHANNELS(C), .DEPTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .input_bit(inBit), .zero(zero),
    .array_ref(arRef), .array_ref_m(arRefM), .segment(seg4), .valid(val4), .busy(busy4));

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [BUS-1:0] pat(input int j);
    logic [BUS-1:0] r;
    for (int k = 0; k < C; k++) r[k*W +: W] = 32'hB000_0000 | W'(j << 8) | W'(k);
    return r;
  endfunction

  function automatic logic [BUS-1:0] garbage();
    logic [BUS-1:0] r;
    for (int k = 0; k < C; k++) r[k*W +: W] = 32'hDEAD_0000 | W'(k);
    return r;
  endfunction

  function automatic logic [BUS-1:0] lanes(input logic [W-1:0] base);
    logic [BUS-1:0] r;
    for (int k = 0; k < C; k++) r[k*W +: W] = base + W'(k);
    return r;
  endfunction

  // Single start on the DEPTH=1 instance; returns what is observed two cycles later.
  task automatic runD1(output logic [BUS-1:0] s, output logic v);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    arRef  = garbage();
    arRefM = garbage();
    tick(1);
    s = seg1;
    v = val1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    tick(2);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      vectors++;
      if ({seg1, seg3, seg4} !== '0) begin
        miscompares++;
        $display("FAIL reset_segment cycle %0d: got %h/%h/%h expected 0", i, seg1, seg3, seg4);
      end
      vectors++;
      if ({val1, val3, val4} !== 3'b000) begin
        miscompares++;
        $display("FAIL reset_valid cycle %0d: got %b expected 000", i, {val1, val3, val4});
      end
      vectors++;
      if ({busy1, busy3, busy4} !== 3'b000) begin
        miscompares++;
        $display("FAIL reset_busy cycle %0d: got %b expected 000", i, {busy1, busy3, busy4});
      end
    end
  endtask

  task automatic test_eq();
    logic [BUS-1:0] expSeg;
    logic [BUS-1:0] s;
    logic           v;
    tick(6);
    for (int k = 0; k < C; k++) inBit[k*W +: W] = (k == 1) ? 32'd5 : W'(k);
    zero   = '0;
    mode   = MODE_EQ;
    arRef  = lanes(32'hAAAA_0000);
    arRefM = lanes(32'h5555_0000);
    expSeg = lanes(32'h5555_0000);
    expSeg[0 +: W] = 32'hAAAA_0000;

    start = 1'b1;
    tick(1);
    start = 1'b0;
    arRef  = garbage();
    arRefM = garbage();
    vectors++;
    if (val1 !== 1'b0 || busy1 !== 1'b1) begin
      miscompares++;
      $display("FAIL eq_cycle1: got valid=%b busy=%b expected valid=0 busy=1", val1, busy1);
    end
    tick(1);
    vectors++;
    if (val1 !== 1'b1 || busy1 !== 1'b0) begin
      miscompares++;
      $display("FAIL eq_cycle2: got valid=%b busy=%b expected valid=1 busy=0", val1, busy1);
    end
    vectors++;
    if (seg1 !== expSeg) begin
      miscompares++;
      $display("FAIL eq_segment: got %h expected %h", seg1, expSeg);
    end
    tick(1);
    vectors++;
    if (val1 !== 1'b0 || busy1 !== 1'b0 || seg1 !== expSeg) begin
      miscompares++;
      $display("FAIL eq_hold: got valid=%b busy=%b seg=%h expected 0 0 %h", val1, busy1, seg1, expSeg);
    end

    // Same lane operands under NE invert the choice in every lane.
    mode   = MODE_NE;
    arRef  = lanes(32'hAAAA_0000);
    arRefM = lanes(32'h5555_0000);
    expSeg = lanes(32'hAAAA_0000);
    expSeg[0 +: W] = 32'h5555_0000;
    runD1(s, v);
    vectors++;
    if (v !== 1'b1 || s !== expSeg) begin
      miscompares++;
      $display("FAIL ne_segment: got valid=%b seg=%h expected valid=1 seg=%h", v, s, expSeg);
    end
  endtask

  task automatic test_slt();
    logic [BUS-1:0] expSeg;
    logic [BUS-1:0] s;
    logic           v;
    tick(4);
    inBit  = '1;
    zero   = '0;
    mode   = MODE_SLT;
    arRef  = lanes(32'h1000_0000);
    arRefM = lanes(32'h2000_0000);
    runD1(s, v);
    vectors++;
    if (v !== 1'b1 || s !== lanes(32'h1000_0000)) begin
      miscompares++;
      $display("FAIL slt_negative: got valid=%b seg=%h expected valid=1 seg=%h", v, s, lanes(32'h1000_0000));
    end

    mode   = MODE_FORCE_ELSE;
    arRef  = lanes(32'h1000_0000);
    arRefM = lanes(32'h2000_0000);
    runD1(s, v);
    vectors++;
    if (v !== 1'b1 || s !== lanes(32'h2000_0000)) begin
      miscompares++;
      $display("FAIL force_else: got valid=%b seg=%h expected valid=1 seg=%h", v, s, lanes(32'h2000_0000));
    end

    // Lane k compares k against 5: lanes 0..4 are less, lane 5 is equal (not less).
    mode = MODE_SLT;
    zero = 32'd5;
    for (int k = 0; k < C; k++) inBit[k*W +: W] = W'(k);
    arRef  = lanes(32'h1000_0000);
    arRefM = lanes(32'h2000_0000);
    expSeg = lanes(32'h2000_0000);
    for (int k = 0; k < 5; k++) expSeg[k*W +: W] = 32'h1000_0000 + W'(k);
    runD1(s, v);
    vectors++;
    if (v !== 1'b1 || s !== expSeg) begin
      miscompares++;
      $display("FAIL slt_boundary: got valid=%b seg=%h expected valid=1 seg=%h", v, s, expSeg);
    end
  endtask

  task automatic test_back_to_back();
    int s;
    int j;
    logic expV, expB;
    tick(6);
    mode  = MODE_FORCE_ELSE;
    arRef = garbage();
    for (int t = 0; t < 12; t++) begin
      if (t < 6) begin
        start  = 1'b1;
        arRefM = pat(t);
      end else begin
        start  = 1'b0;
        arRefM = garbage();
      end
      tick(1);
      s = t + 1;
      expV = (s >= 5 && s <= 10);
      expB = (s >= 1 && s <= 9);
      vectors++;
      if (val4 !== expV || busy4 !== expB) begin
        miscompares++;
        $display("FAIL b2b_flags cycle %0d: got valid=%b busy=%b expected valid=%b busy=%b",
                 s, val4, busy4, expV, expB);
      end
      if (s >= 5) begin
        j = (s - 5 > 5) ? 5 : s - 5;
        vectors++;
        if (seg4 !== pat(j)) begin
          miscompares++;
          $display("FAIL b2b_segment cycle %0d: got %h expected %h", s, seg4, pat(j));
        end
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset_mid();
    tick(6);
    mode   = MODE_FORCE_ELSE;
    arRefM = pat(9);
    start  = 1'b1;
    tick(1);
    start  = 1'b0;
    tick(1);
    reset  = 1'b1;
    start  = 1'b1;
    tick(1);
    reset  = 1'b0;
    start  = 1'b0;
    vectors++;
    if (seg4 !== '0 || val4 !== 1'b0 || busy4 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_clear: got valid=%b busy=%b seg=%h expected all 0", val4, busy4, seg4);
    end
    for (int i = 0; i < 8; i++) begin
      tick(1);
      vectors++;
      if (val4 !== 1'b0 || seg4 !== '0) begin
        miscompares++;
        $display("FAIL reset_mid_flushed cycle %0d: got valid=%b seg=%h expected valid=0 seg=0",
                 i, val4, seg4);
      end
    end
  endtask

  task automatic test_alternate();
    int s;
    int j;
    logic expV;
    tick(6);
    mode  = MODE_FORCE_ELSE;
    arRef = garbage();
    for (int t = 0; t < 12; t++) begin
      start  = (t % 2 == 0) && (t < 8);
      arRefM = start ? pat(t / 2) : garbage();
      tick(1);
      s = t + 1;
      expV = (s >= 4) && (s <= 10) && (s % 2 == 0);
      vectors++;
      if (val3 !== expV) begin
        miscompares++;
        $display("FAIL alt_valid cycle %0d: got %b expected %b", s, val3, expV);
      end
      if (s >= 4) begin
        j = ((s - 4) / 2 > 3) ? 3 : (s - 4) / 2;
        vectors++;
        if (seg3 !== pat(j)) begin
          miscompares++;
          $display("FAIL alt_segment cycle %0d: got %h expected %h", s, seg3, pat(j));
        end
      end
    end
    start = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    mode   = MODE_EQ;
    inBit  = '0;
    zero   = '0;
    arRef  = '0;
    arRefM = '0;
    test_reset();
    test_eq();
    test_slt();
    test_back_to_back();
    test_reset_mid();
    test_alternate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
